// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI pixel link.
//   spi_state_t     : link FSM states (IDLE, LOAD, ACTIVE)
//   SPI_SYNC_STAGES : metastability flops ahead of any use of an async SPI pin
//   SPI_TX_FILL     : byte sent on MISO when the holding register is empty
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACTIVE
  } spi_state_t;

  localparam int unsigned SPI_SYNC_STAGES = 2;
  localparam logic [7:0]  SPI_TX_FILL     = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous SPI pin.
//   clk, rst : system clock, async active-high reset
//   din_i    : asynchronous input pin
//   level_o  : synchronized level
//   rise_o   : one-clk pulse on a synchronized 0->1 transition
//   fall_o   : one-clk pulse on a synchronized 1->0 transition
// RESET_VAL is the pin's idle level, so leaving reset never fakes an edge.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SPI_SYNC_STAGES-1:0] sync_q;
  logic                       prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SPI_SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], din_i};
      prev_q <= sync_q[SPI_SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SPI_SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_pixel_link.sv
// SPI mode-0 slave (MSB first) between the MCU and the dithering datapath.
// SCLK is oversampled on clk; it never clocks any flop.
//   clk, rst           : system clock, async active-high reset
//   sclk, cs_n, mosi   : asynchronous SPI pins from the MCU
//   miso               : SPI data out (MSB of the TX shift register)
//   rx_byte, rx_valid  : received byte and its one-clk strobe
//   tx_byte, tx_valid  : byte offered for transmission
//   tx_ready           : transmit holding register empty
//   tx_underrun        : strobe, fill byte sent because holding was empty
//   frame_abort        : strobe, cs_n rose mid-byte
//   frame_done         : strobe, BYTES_PER_FRAME bytes received
//   byte_count         : bytes received in the current image frame
module spi_pixel_link
  import spi_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED     = 50000000,
  parameter int unsigned RGB_SIZE        = 8,
  parameter int unsigned BYTES_PER_FRAME = 4096,
  parameter int unsigned FRAME_CNT_WIDTH = $clog2(BYTES_PER_FRAME)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       mosi,
  output logic                       miso,
  output logic [RGB_SIZE-1:0]        rx_byte,
  output logic                       rx_valid,
  input  logic [RGB_SIZE-1:0]        tx_byte,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       tx_underrun,
  output logic                       frame_abort,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] byte_count
);

  localparam int unsigned BIT_W = $clog2(RGB_SIZE);
  localparam logic [BIT_W-1:0]           LAST_BIT  = BIT_W'(RGB_SIZE - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] LAST_BYTE = FRAME_CNT_WIDTH'(BYTES_PER_FRAME - 1);
  localparam logic [RGB_SIZE-1:0]        TX_FILL   = RGB_SIZE'(SPI_TX_FILL);

  if (CLOCK_SPEED < 4) begin : g_bad_clock
    $error("CLOCK_SPEED must allow SCLK <= CLOCK_SPEED/4");
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_level_unused, cs_level_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din_i(sclk),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din_i(cs_n),
    .level_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  spi_state_t                 state_q, state_d;
  logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [RGB_SIZE-2:0]        rx_shift_q, rx_shift_d;
  logic [RGB_SIZE-1:0]        rx_byte_q, rx_byte_d;
  logic                       rx_valid_q, rx_valid_d;
  logic [RGB_SIZE-1:0]        tx_shift_q, tx_shift_d;
  logic [RGB_SIZE-1:0]        hold_q, hold_d;
  logic                       hold_full_q, hold_full_d;
  logic                       byte_seen_q, byte_seen_d;
  logic                       underrun_q, underrun_d;
  logic                       abort_q, abort_d;
  logic                       done_q, done_d;
  logic [FRAME_CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic                       reload, hold_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      byte_seen_q <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      byte_seen_q <= byte_seen_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    byte_seen_d = byte_seen_q;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    done_d      = 1'b0;
    byte_cnt_d  = byte_cnt_q;
    reload      = 1'b0;
    hold_take   = tx_valid && !hold_full_q;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        bit_cnt_d   = '0;
        byte_seen_d = 1'b0;
        reload      = 1'b1;
        state_d     = ACTIVE;
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (bit_cnt_q != '0) begin
            abort_d   = 1'b1;
            bit_cnt_d = '0;
          end
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[RGB_SIZE-3:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              rx_byte_d   = {rx_shift_q, mosi_s};
              rx_valid_d  = 1'b1;
              byte_seen_d = 1'b1;
              bit_cnt_d   = '0;
              if (byte_cnt_q == LAST_BYTE) begin
                byte_cnt_d = '0;
                done_d     = 1'b1;
              end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
              end
            end
          end
          // bit_cnt==0 on a falling edge means the previous byte just ended
          // and the MCU will sample the next byte's MSB on the coming rise.
          if (sclk_fall) begin
            if (bit_cnt_q != '0) tx_shift_d = {tx_shift_q[RGB_SIZE-2:0], 1'b0};
            else if (byte_seen_q) reload = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A reload consumes the old holding content; a same-clk capture refills it.
    if (reload) begin
      if (hold_full_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = TX_FILL;
        underrun_d = 1'b1;
      end
      hold_full_d = 1'b0;
    end
    if (hold_take) begin
      hold_d      = tx_byte;
      hold_full_d = 1'b1;
    end
  end

  assign miso        = tx_shift_q[RGB_SIZE-1];
  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = !hold_full_q;
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;
  assign frame_done  = done_q;
  assign byte_count  = byte_cnt_q;

endmodule

// File: tb/tb_spi_pixel_link.sv
module tb_spi_pixel_link;

  localparam int unsigned BPF = 4;
  localparam int unsigned FCW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sclk = 1'b0;
  logic           cs_n = 1'b1;
  logic           mosi = 1'b0;
  logic           miso;
  logic [7:0]     rx_byte;
  logic           rx_valid;
  logic [7:0]     tx_byte = 8'h00;
  logic           tx_valid = 1'b0;
  logic           tx_ready;
  logic           tx_underrun;
  logic           frame_abort;
  logic           frame_done;
  logic [FCW-1:0] byte_count;

  spi_pixel_link #(
    .CLOCK_SPEED(50000000),
    .RGB_SIZE(8),
    .BYTES_PER_FRAME(BPF),
    .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .frame_abort(frame_abort),
    .frame_done(frame_done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling clk edge.
  int n_rxv, n_unr, n_abt, n_fd;
  int rxv_bc[8];
  int rxv_unr[8];
  int fd_with_rxv;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (n_rxv < 8) begin
        rxv_bc[n_rxv]  = int'(byte_count);
        rxv_unr[n_rxv] = n_unr;
      end
      n_rxv++;
    end
    if (tx_underrun) n_unr++;
    if (frame_abort) n_abt++;
    if (frame_done) begin
      n_fd++;
      fd_with_rxv = int'(rx_valid);
    end
  end

  task automatic clear_counts();
    n_rxv = 0; n_unr = 0; n_abt = 0; n_fd = 0; fd_with_rxv = 0;
    for (int i = 0; i < 8; i++) begin
      rxv_bc[i] = -1;
      rxv_unr[i] = -1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 clear_counts();
  endtask

  task automatic offer(input logic [7:0] b);
    @(negedge clk);
    tx_byte = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!tx_ready) break;
    end
    tx_valid = 1'b0;
    check("offer_taken", {31'd0, tx_ready}, 32'd0);
  endtask

  task automatic cs_start();
    @(negedge clk);
    cs_n = 1'b0;
    #50;
  endtask

  task automatic cs_end();
    #40 cs_n = 1'b1;
    #80;
  endtask

  // SCLK = clk/8; MISO captured right before each SCLK rise (mode 0).
  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      #40;
      mi[7-i] = miso;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
    #40;
  endtask

  logic [7:0] mi1, mi2;

  initial begin
    clear_counts();

    // Reset state and single byte receive
    do_reset();
    check("rst_rx_byte", {24'd0, rx_byte}, 32'h0);
    check("rst_byte_count", {30'd0, byte_count}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_miso", {31'd0, miso}, 32'd0);
    offer(8'h11);
    cs_start();
    xfer(8'hA5, 8, mi1);
    cs_end();
    check("t1_rxv_count", n_rxv, 32'd1);
    check("t1_rx_byte", {24'd0, rx_byte}, 32'hA5);
    check("t1_byte_count", {30'd0, byte_count}, 32'd1);
    check("t1_bc_at_rxv", rxv_bc[0], 32'd1);
    check("t1_unr_before_rxv", rxv_unr[0], 32'd0);
    check("t1_abort", n_abt, 32'd0);
    check("t1_done", n_fd, 32'd0);
    check("t1_miso", {24'd0, mi1}, 32'h11);

    // MISO serialisation and holding release in LOAD
    do_reset();
    offer(8'h3C);
    cs_start();
    check("t2_tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
    xfer(8'h81, 8, mi1);
    cs_end();
    check("t2_miso", {24'd0, mi1}, 32'h3C);
    check("t2_rx_byte", {24'd0, rx_byte}, 32'h81);

    // Underrun at the byte boundary
    do_reset();
    offer(8'h3C);
    cs_start();
    xfer(8'h12, 8, mi1);
    xfer(8'h34, 8, mi2);
    cs_end();
    check("t3_miso1", {24'd0, mi1}, 32'h3C);
    check("t3_miso2", {24'd0, mi2}, 32'h00);
    check("t3_unr_at_boundary", rxv_unr[1], 32'd1);
    check("t3_rx_byte", {24'd0, rx_byte}, 32'h34);
    check("t3_byte_count", {30'd0, byte_count}, 32'd2);

    // Abort after 5 bits, then a clean byte
    do_reset();
    cs_start();
    xfer(8'hF0, 5, mi1);
    cs_end();
    check("t4_abort", n_abt, 32'd1);
    check("t4_no_rxv", n_rxv, 32'd0);
    check("t4_bc_kept", {30'd0, byte_count}, 32'd0);
    cs_start();
    xfer(8'h5A, 8, mi1);
    cs_end();
    check("t4_rxv_count", n_rxv, 32'd1);
    check("t4_rx_byte", {24'd0, rx_byte}, 32'h5A);
    check("t4_byte_count", {30'd0, byte_count}, 32'd1);
    check("t4_abort_once", n_abt, 32'd1);

    // Frame wrap at BYTES_PER_FRAME
    do_reset();
    cs_start();
    for (int k = 1; k <= 5; k++) xfer(8'(k), 8, mi1);
    cs_end();
    check("t5_rxv_count", n_rxv, 32'd5);
    check("t5_done_count", n_fd, 32'd1);
    check("t5_done_with_rxv", fd_with_rxv, 32'd1);
    check("t5_bc_at_4th", rxv_bc[3], 32'd0);
    check("t5_bc_at_5th", rxv_bc[4], 32'd1);
    check("t5_byte_count", {30'd0, byte_count}, 32'd1);
    check("t5_rx_byte", {24'd0, rx_byte}, 32'h05);

    // Reset in the middle of a byte
    do_reset();
    cs_start();
    xfer(8'h77, 8, mi1);
    cs_end();
    offer(8'hF0);
    cs_start();
    offer(8'h0F);
    xfer(8'hFF, 3, mi1);
    check("t6_pre_miso", {31'd0, miso}, 32'd1);
    check("t6_pre_bc", {30'd0, byte_count}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_rx_byte", {24'd0, rx_byte}, 32'h0);
    check("t6_rst_bc", {30'd0, byte_count}, 32'd0);
    check("t6_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("t6_rst_miso", {31'd0, miso}, 32'd0);
    check("t6_rst_strobes", {28'd0, rx_valid, tx_underrun, frame_abort, frame_done}, 32'd0);
    do_reset();
    cs_start();
    xfer(8'hFF, 8, mi1);
    cs_end();
    check("t6_rx_byte", {24'd0, rx_byte}, 32'hFF);
    check("t6_byte_count", {30'd0, byte_count}, 32'd1);
    check("t6_rxv_count", n_rxv, 32'd1);
    check("t6_abort", n_abt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
